// File: rtl/debug_cmd_initiator.sv
// Host-side master for the byte-wide debug command/response link: issues one command
// strobe per request and packs the response. Optional stats counters: DBG_INIT_STATS_EN.
module debug_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_opcode,
  output logic [7:0]  debug_cmd,
  output logic        debug_cmd_valid,
  input  logic [7:0]  debug_resp,
  input  logic        debug_resp_valid,
  output logic        busy,
  output logic        rsp_valid,
  output logic [7:0]  rsp_opcode,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_len,
  output logic        rsp_err_echo,
  output logic        rsp_err_timeout,
  output logic [7:0]  stray_count
`ifdef DBG_INIT_STATS_EN
  ,
  output logic [15:0] txn_count,
  output logic [15:0] err_count
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned TMR_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STAT_W = 16;

  // The DONE cycle itself is the last idle cycle of the timeout window.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_COLLECT,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0]  exp_len_q, exp_len_d;
  logic [BYTE_W-1:0] exp_echo_q, exp_echo_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic              req_ready_d, busy_d, rsp_valid_d;
  logic [BYTE_W-1:0] debug_cmd_d;
  logic              debug_cmd_valid_d;
  logic [BYTE_W-1:0] rsp_opcode_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic [LEN_W-1:0]  rsp_len_d;
  logic              rsp_err_echo_d, rsp_err_timeout_d;
  logic [BYTE_W-1:0] stray_count_d;

  // Response length per opcode, including the echo byte.
  function automatic logic [LEN_W-1:0] exp_len_f(input logic [BYTE_W-1:0] op);
    case (op)
      8'h00, 8'h20: exp_len_f = LEN_W'(1);
      8'h01, 8'hF0: exp_len_f = LEN_W'(4);
      8'h02, 8'h04: exp_len_f = LEN_W'(3);
      8'h03, 8'h06: exp_len_f = LEN_W'(5);
      default:      exp_len_f = LEN_W'(2);
    endcase
  endfunction

  // Known opcodes echo themselves; unknown ones are answered with FF.
  function automatic logic [BYTE_W-1:0] exp_echo_f(input logic [BYTE_W-1:0] op);
    case (op)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
      8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'hF0: exp_echo_f = op;
      default:                                         exp_echo_f = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      exp_len_q       <= '0;
      exp_echo_q      <= '0;
      timer_q         <= '0;
      req_ready       <= 1'b0;
      busy            <= 1'b0;
      debug_cmd       <= '0;
      debug_cmd_valid <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_opcode      <= '0;
      rsp_data        <= '0;
      rsp_len         <= '0;
      rsp_err_echo    <= 1'b0;
      rsp_err_timeout <= 1'b0;
      stray_count     <= '0;
    end else begin
      state_q         <= state_d;
      exp_len_q       <= exp_len_d;
      exp_echo_q      <= exp_echo_d;
      timer_q         <= timer_d;
      req_ready       <= req_ready_d;
      busy            <= busy_d;
      debug_cmd       <= debug_cmd_d;
      debug_cmd_valid <= debug_cmd_valid_d;
      rsp_valid       <= rsp_valid_d;
      rsp_opcode      <= rsp_opcode_d;
      rsp_data        <= rsp_data_d;
      rsp_len         <= rsp_len_d;
      rsp_err_echo    <= rsp_err_echo_d;
      rsp_err_timeout <= rsp_err_timeout_d;
      stray_count     <= stray_count_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d           = state_q;
    exp_len_d         = exp_len_q;
    exp_echo_d        = exp_echo_q;
    timer_d           = timer_q;
    rsp_opcode_d      = rsp_opcode;
    rsp_data_d        = rsp_data;
    rsp_len_d         = rsp_len;
    rsp_err_echo_d    = rsp_err_echo;
    rsp_err_timeout_d = rsp_err_timeout;
    stray_count_d     = stray_count;
    req_ready_d       = 1'b0;
    busy_d            = 1'b0;
    debug_cmd_d       = '0;
    debug_cmd_valid_d = 1'b0;
    rsp_valid_d       = 1'b0;

    if (debug_resp_valid && (state_q != ST_COLLECT) && (stray_count != 8'hFF)) begin
      stray_count_d = stray_count + BYTE_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          rsp_opcode_d      = req_opcode;
          exp_len_d         = exp_len_f(req_opcode);
          exp_echo_d        = exp_echo_f(req_opcode);
          rsp_data_d        = '0;
          rsp_len_d         = '0;
          rsp_err_echo_d    = 1'b0;
          rsp_err_timeout_d = 1'b0;
          state_d           = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d   = '0;
        rsp_len_d = '0;
        state_d   = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (debug_resp_valid) begin
          timer_d = '0;
          case (rsp_len)
            3'd0:    rsp_err_echo_d = (debug_resp != exp_echo_q);
            3'd1:    rsp_data_d[7:0]   = debug_resp;
            3'd2:    rsp_data_d[15:8]  = debug_resp;
            3'd3:    rsp_data_d[23:16] = debug_resp;
            3'd4:    rsp_data_d[31:24] = debug_resp;
            default: ;
          endcase
          rsp_len_d = rsp_len + LEN_W'(1);
          if (rsp_len_d == exp_len_q) begin
            state_d = ST_DONE;
          end
        end else if (timer_q == TMR_LAST) begin
          rsp_err_timeout_d = 1'b1;
          state_d           = ST_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d       = (state_d == ST_IDLE);
    busy_d            = (state_d != ST_IDLE);
    debug_cmd_valid_d = (state_d == ST_ISSUE);
    debug_cmd_d       = debug_cmd_valid_d ? rsp_opcode_d : '0;
    rsp_valid_d       = (state_d == ST_DONE);
  end

`ifdef DBG_INIT_STATS_EN
  // Saturating transaction and error tallies, advanced on each completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
      err_count <= '0;
    end else if (rsp_valid) begin
      if (txn_count != '1) begin
        txn_count <= txn_count + STAT_W'(1);
      end
      if ((rsp_err_echo || rsp_err_timeout) && (err_count != '1)) begin
        err_count <= err_count + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_debug_cmd_initiator.sv
// Randomized self-checking bench for debug_cmd_initiator against a transaction-level model.
module tb_debug_cmd_initiator;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_opcode = '0;
  logic [7:0]  debug_cmd;
  logic        debug_cmd_valid;
  logic [7:0]  debug_resp = '0;
  logic        debug_resp_valid = 1'b0;
  logic        busy;
  logic        rsp_valid;
  logic [7:0]  rsp_opcode;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_len;
  logic        rsp_err_echo;
  logic        rsp_err_timeout;
  logic [7:0]  stray_count;
`ifdef DBG_INIT_STATS_EN
  logic [15:0] txn_count;
  logic [15:0] err_count;
`endif

  debug_cmd_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_opcode(req_opcode),
    .debug_cmd(debug_cmd),
    .debug_cmd_valid(debug_cmd_valid),
    .debug_resp(debug_resp),
    .debug_resp_valid(debug_resp_valid),
    .busy(busy),
    .rsp_valid(rsp_valid),
    .rsp_opcode(rsp_opcode),
    .rsp_data(rsp_data),
    .rsp_len(rsp_len),
    .rsp_err_echo(rsp_err_echo),
    .rsp_err_timeout(rsp_err_timeout),
    .stray_count(stray_count)
`ifdef DBG_INIT_STATS_EN
    ,
    .txn_count(txn_count),
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_cmd = 0;
  int unsigned n_rsp = 0;
  int unsigned cmd_cyc = 0;
  logic [7:0]  cmd_byte = '0;
  int unsigned stray_m = 0;
  int unsigned txn_m = 0;
  int unsigned err_m = 0;

  // Passive monitor of the two strobes.
  always @(negedge clk) begin
    if (debug_cmd_valid) begin
      n_cmd    <= n_cmd + 1;
      cmd_cyc  <= cyc;
      cmd_byte <= debug_cmd;
    end
    if (rsp_valid) n_rsp <= n_rsp + 1;
  end

  function automatic int unsigned m_len(input logic [7:0] op);
    case (op)
      8'h00, 8'h20: return 1;
      8'h01, 8'hF0: return 4;
      8'h02, 8'h04: return 3;
      8'h03, 8'h06: return 5;
      default:      return 2;
    endcase
  endfunction

  function automatic logic [7:0] m_echo(input logic [7:0] op);
    if (op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                   8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'hF0}) return op;
    return 8'hFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic send_stray(input int unsigned n);
    debug_resp_valid = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      debug_resp = 8'($urandom);
      @(negedge clk);
    end
    debug_resp_valid = 1'b0;
    stray_m = (stray_m + n > 255) ? 255 : stray_m + n;
    check("stray_count", 32'(stray_count), 32'(stray_m));
  endtask

  // Issue one request, play the responder bytes with the given idle gaps, check the result.
  task automatic run_txn(input logic [7:0] op, input logic [7:0] b[$], input int unsigned g[$],
                         input bit poke);
    int unsigned t, last, c, elen, cnt, exp_cyc, c0, r0;
    int k;
    logic [31:0] data;
    logic eerr, terr;
    wait_ready();
    c0 = n_cmd;
    r0 = n_rsp;
    req_valid  = 1'b1;
    req_opcode = op;
    t = cyc;
    @(negedge clk);
    req_valid  = 1'b0;
    req_opcode = 8'($urandom);
    last = t + 1;
    elen = m_len(op);
    cnt  = 0;
    data = '0;
    eerr = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      if (cnt >= elen || g[i] > TO - 2) break;
      c = last + g[i] + 1;
      if (poke && cnt == 1 && g[i] >= 1) begin
        check("busy_collect", 32'(busy), 32'd1);
        check("ready_collect", 32'(req_ready), 32'd0);
        req_valid  = 1'b1;
        req_opcode = 8'h00;
        @(negedge clk);
        req_valid  = 1'b0;
      end
      while (cyc < c) @(negedge clk);
      debug_resp_valid = 1'b1;
      debug_resp       = b[i];
      @(negedge clk);
      debug_resp_valid = 1'b0;
      debug_resp       = 8'($urandom);
      if (cnt == 0) eerr = (b[i] != m_echo(op));
      else data[8*(cnt-1) +: 8] = b[i];
      cnt++;
      last = c;
    end
    terr    = (cnt < elen);
    exp_cyc = terr ? last + TO : last + 1;
    k = 0;
    while (!rsp_valid && k < 2 * TO + 8) begin
      @(negedge clk);
      k++;
    end
    check("rsp_seen", 32'(rsp_valid), 32'd1);
    check("rsp_cycle", cyc, exp_cyc);
    check("rsp_opcode", 32'(rsp_opcode), 32'(op));
    check("rsp_data", rsp_data, data);
    check("rsp_len", 32'(rsp_len), cnt);
    check("rsp_err_echo", 32'(rsp_err_echo), 32'(eerr));
    check("rsp_err_timeout", 32'(rsp_err_timeout), 32'(terr));
    check("busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("rsp_pulse_one", 32'(rsp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("rsp_data_hold", rsp_data, data);
    check("cmd_count", n_cmd - c0, 32'd1);
    check("cmd_cycle", cmd_cyc, t + 1);
    check("cmd_byte", 32'(cmd_byte), 32'(op));
    check("rsp_count", n_rsp - r0, 32'd1);
    if (txn_m < 16'hFFFF) txn_m++;
    if ((eerr || terr) && err_m < 16'hFFFF) err_m++;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0]  bq[$];
    int unsigned gq[$];
    logic [7:0]  known[14];
    logic [7:0]  op;
    int unsigned elen, nsend, r0;

    known = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'hF0};

    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outs", {28'd0, rsp_valid, debug_cmd_valid, rsp_err_echo, rsp_err_timeout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Version read
    bq = '{8'hF0, 8'h01, 8'h00, 8'h00}; gq = '{0, 0, 0, 0};
    run_txn(8'hF0, bq, gq, 1'b0);
    // Packet count read with 3-cycle gaps
    bq = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12}; gq = '{0, 3, 3, 3, 3};
    run_txn(8'h03, bq, gq, 1'b0);
    // Unknown opcode answered with FF
    bq = '{8'hFF, 8'h7E}; gq = '{1, 0};
    run_txn(8'h7E, bq, gq, 1'b0);
    // Timeout after two bytes
    bq = '{8'h06, 8'hAA}; gq = '{0, 0};
    run_txn(8'h06, bq, gq, 1'b0);
    // Echo error, then strays up to saturation
    bq = '{8'h02, 8'hA1, 8'hA2, 8'hA3}; gq = '{0, 1, 0, 2};
    run_txn(8'h01, bq, gq, 1'b0);
    send_stray(1);
    send_stray(299);
    check("stray_saturated", 32'(stray_count), 32'd255);
    // Request attempted during COLLECT
    bq = '{8'h02, 8'h5A, 8'hC3}; gq = '{0, 2, 0};
    run_txn(8'h02, bq, gq, 1'b1);
    // Byte arriving on the last cycle of the timeout window wins
    bq = '{8'h05, 8'h33}; gq = '{TO - 2, TO - 2};
    run_txn(8'h05, bq, gq, 1'b0);
    // No response at all
    bq.delete(); gq.delete();
    run_txn(8'h20, bq, gq, 1'b0);

    // Reset in the middle of COLLECT
    wait_ready();
    req_valid = 1'b1; req_opcode = 8'h03;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    debug_resp_valid = 1'b1; debug_resp = 8'h03;
    @(negedge clk);
    debug_resp = 8'h11;
    @(negedge clk);
    debug_resp_valid = 1'b0;
    check("busy_before_reset", 32'(busy), 32'd1);
    r0 = n_rsp;
    rst_n = 1'b0;
    #1;
    check("midreset_flags",
          {24'd0, req_ready, busy, rsp_valid, debug_cmd_valid, rsp_err_echo, rsp_err_timeout, 2'b00},
          32'd0);
    check("midreset_data", rsp_data, 32'd0);
    check("midreset_len_op", {21'd0, rsp_len, rsp_opcode}, 32'd0);
    check("midreset_stray_cmd", {16'd0, stray_count, debug_cmd}, 32'd0);
    stray_m = 0; txn_m = 0; err_m = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (TO + 10) @(negedge clk);
    check("no_rsp_after_reset", n_rsp - r0, 32'd0);
    bq = '{8'h21, 8'h9C}; gq = '{0, 0};
    run_txn(8'h21, bq, gq, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 25; n++) begin
      op   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : known[$urandom_range(0, 13)];
      elen = m_len(op);
      nsend = ($urandom_range(0, 5) == 0) ? $urandom_range(0, elen - 1) : elen;
      bq.delete(); gq.delete();
      for (int i = 0; i < int'(nsend); i++) begin
        if (i == 0) bq.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : m_echo(op));
        else        bq.push_back(8'($urandom));
        gq.push_back(($urandom_range(0, 9) == 0) ? TO - 2 : $urandom_range(0, 3));
      end
      run_txn(op, bq, gq, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 3) == 0) send_stray($urandom_range(1, 4));
    end

`ifdef DBG_INIT_STATS_EN
    @(negedge clk);
    check("txn_count", 32'(txn_count), txn_m);
    check("err_count", 32'(err_count), err_m);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
